hilo_unit_ctrl: RTL and testbench

Sequencing controller for the multicycle MULT/DIV datapath. It sits between the main control unit and the shared divisor and multiplier units. It accepts one HI/LO operation at a time, arms and runs the selected unit, watches for completion, divide-by-zero and timeout, and owns the architectural HI/LO registers. The control unit holds in its current state while op_ready is low.

---
 rtl/hilo_unit_ctrl_pkg.sv | 24 ++
 rtl/hilo_unit_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hilo_unit_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_unit_ctrl_pkg.sv
// Shared encodings for the HI/LO sequencing controller: operation codes,
// controller states and default timing limits.
package hilo_unit_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_MULT = 2'b00,
      OP_DIV  = 2'b01,
      OP_MTHI = 2'b10,
      OP_MTLO = 2'b11
   } op_code_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARM      = 3'd1,
      RUN      = 3'd2,
      DONE     = 3'd3,
      ERR_ZERO = 3'd4,
      ERR_TO   = 3'd5
   } state_t;

   localparam int TIMEOUT_DEFAULT = 64;
   localparam int CW_DEFAULT      = 7;

endpackage

// File: rtl/hilo_unit_ctrl.sv
// Sequences one MULT/DIV/MTHI/MTLO at a time, arms and watches the shared
// multiplier/divisor and owns the architectural HI/LO registers.
module hilo_unit_ctrl
   import hilo_unit_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CW      = CW_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [1:0]  op_code,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        op_ready,
   output logic        done,
   output logic        div_zero_exc,
   output logic        timeout_err,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_ctrl,
   output logic        div_rst,
   output logic [31:0] div_dividendo,
   output logic [31:0] div_divisor,
   input  logic        div_out,
   input  logic        div_zero,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   output logic        mult_ctrl,
   output logic        mult_rst,
   input  logic        mult_out,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo
);

   state_t          r_state;
   state_t          w_state_next;
   op_code_t        r_op;
   op_code_t        w_op_next;
   logic [31:0]     r_hi, w_hi_next;
   logic [31:0]     r_lo, w_lo_next;
   logic [31:0]     r_opa, w_opa_next;
   logic [31:0]     r_opb, w_opb_next;
   logic [CW-1:0]   r_cnt, w_cnt_next;
   logic            r_op_ready;
   logic            r_done;
   logic            r_div_zero_exc;
   logic            r_timeout_err;
   logic            r_div_ctrl;
   logic            r_div_rst;
   logic            r_mult_ctrl;
   logic            r_mult_rst;
   logic            w_is_div;
   logic            w_unit_done;

   assign w_is_div    = (r_op == OP_DIV);
   assign w_unit_done = w_is_div ? div_out : mult_out;

   always_comb begin
      w_state_next = r_state;
      w_op_next    = r_op;
      w_hi_next    = r_hi;
      w_lo_next    = r_lo;
      w_opa_next   = r_opa;
      w_opb_next   = r_opb;
      w_cnt_next   = r_cnt;
      case (r_state)
         IDLE: begin
            if (op_valid && r_op_ready) begin
               if (op_code == OP_MTHI) begin
                  w_hi_next    = op_a;
                  w_state_next = DONE;
               end else if (op_code == OP_MTLO) begin
                  w_lo_next    = op_a;
                  w_state_next = DONE;
               end else begin
                  w_op_next    = op_code_t'(op_code);
                  w_opa_next   = op_a;
                  w_opb_next   = op_b;
                  w_state_next = ARM;
               end
            end
         end
         ARM: begin
            w_cnt_next   = '0;
            w_state_next = RUN;
         end
         RUN: begin
            w_cnt_next = r_cnt + CW'(1);
            // Divide-by-zero outranks a result strobe; completion outranks timeout.
            if (w_is_div && div_zero) begin
               w_state_next = ERR_ZERO;
            end else if (w_unit_done) begin
               w_hi_next    = w_is_div ? div_hi : mult_hi;
               w_lo_next    = w_is_div ? div_lo : mult_lo;
               w_state_next = DONE;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
               w_state_next = ERR_TO;
            end
         end
         DONE, ERR_ZERO, ERR_TO: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Output flags are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_op           <= OP_MULT;
         r_hi           <= '0;
         r_lo           <= '0;
         r_opa          <= '0;
         r_opb          <= '0;
         r_cnt          <= '0;
         r_op_ready     <= 1'b1;
         r_done         <= 1'b0;
         r_div_zero_exc <= 1'b0;
         r_timeout_err  <= 1'b0;
         r_div_ctrl     <= 1'b0;
         r_div_rst      <= 1'b0;
         r_mult_ctrl    <= 1'b0;
         r_mult_rst     <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_op           <= w_op_next;
         r_hi           <= w_hi_next;
         r_lo           <= w_lo_next;
         r_opa          <= w_opa_next;
         r_opb          <= w_opb_next;
         r_cnt          <= w_cnt_next;
         r_op_ready     <= (w_state_next == IDLE);
         r_done         <= (w_state_next == DONE);
         r_div_zero_exc <= (w_state_next == ERR_ZERO);
         r_timeout_err  <= (w_state_next == ERR_TO);
         r_div_rst      <= (w_state_next == ARM) && (w_op_next == OP_DIV);
         r_mult_rst     <= (w_state_next == ARM) && (w_op_next == OP_MULT);
         r_div_ctrl     <= (w_state_next == RUN) && (w_op_next == OP_DIV);
         r_mult_ctrl    <= (w_state_next == RUN) && (w_op_next == OP_MULT);
      end
   end

   assign op_ready      = r_op_ready;
   assign done          = r_done;
   assign div_zero_exc  = r_div_zero_exc;
   assign timeout_err   = r_timeout_err;
   assign hi            = r_hi;
   assign lo            = r_lo;
   assign div_ctrl      = r_div_ctrl;
   assign div_rst       = r_div_rst;
   assign div_dividendo = r_opa;
   assign div_divisor   = r_opb;
   assign mult_ctrl     = r_mult_ctrl;
   assign mult_rst      = r_mult_rst;

endmodule

// File: tb/tb_hilo_unit_ctrl.sv
// Bench for hilo_unit_ctrl with behavioural divisor and multiplier stubs of
// programmable latency; expectations come from a HI/LO reference model.
module tb_hilo_unit_ctrl;
   import hilo_unit_ctrl_pkg::*;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic [1:0]  op_code = 2'b00;
   logic [31:0] op_a = '0, op_b = '0;
   logic        op_ready, done, div_zero_exc, timeout_err;
   logic [31:0] hi, lo;
   logic        div_ctrl, div_rst, mult_ctrl, mult_rst;
   logic [31:0] div_dividendo, div_divisor;
   logic        div_out, div_zero, mult_out;
   logic [31:0] div_hi, div_lo, mult_hi, mult_lo;

   int checks = 0;
   int errors = 0;

   int          div_lat = 10, mult_lat = 5;
   bit          mult_never = 0, mult_force = 0, div_noise = 0, mult_noise = 0;
   logic [31:0] force_hi = '0, force_lo = '0;
   int          dcnt = 0, mcnt = 0;
   logic [63:0] prod;

   logic [31:0] m_hi = '0, m_lo = '0;

   int res_lat, res_ndone, res_nzero, res_nto;
   bit res_busy_ok, res_ready_after, res_div_seen, res_mult_seen, res_dctrl_pulse;

   always #5 clk = ~clk;

   hilo_unit_ctrl #(.TIMEOUT(TO), .CW(7)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .done(done),
      .div_zero_exc(div_zero_exc), .timeout_err(timeout_err), .hi(hi), .lo(lo),
      .div_ctrl(div_ctrl), .div_rst(div_rst), .div_dividendo(div_dividendo),
      .div_divisor(div_divisor), .div_out(div_out), .div_zero(div_zero),
      .div_hi(div_hi), .div_lo(div_lo), .mult_ctrl(mult_ctrl), .mult_rst(mult_rst),
      .mult_out(mult_out), .mult_hi(mult_hi), .mult_lo(mult_lo)
   );

   // Stub units: count enabled cycles since the arm pulse.
   always @(posedge clk) begin
      if (div_rst) dcnt <= 0;
      else if (div_ctrl) dcnt <= dcnt + 1;
      if (mult_rst) mcnt <= 0;
      else if (mult_ctrl) mcnt <= mcnt + 1;
   end

   always_comb begin
      div_zero = div_noise || (div_ctrl && div_divisor == 32'd0);
      div_out  = div_noise || (div_ctrl && (div_divisor == 32'd0 || dcnt == div_lat));
      div_hi   = 32'hBAD0_0001;
      div_lo   = 32'hBAD0_0002;
      if (!div_noise && div_divisor != 32'd0) begin
         div_lo = $signed(div_dividendo) / $signed(div_divisor);
         div_hi = $signed(div_dividendo) % $signed(div_divisor);
      end
      prod      = longint'($signed(div_dividendo)) * longint'($signed(div_divisor));
      mult_out  = mult_noise || (mult_ctrl && !mult_never && mcnt == mult_lat);
      mult_hi   = mult_noise ? 32'hDEAD_0003 : (mult_force ? force_hi : prod[63:32]);
      mult_lo   = mult_noise ? 32'hDEAD_0004 : (mult_force ? force_lo : prod[31:0]);
   end

   task automatic run_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
      res_lat = 0; res_ndone = 0; res_nzero = 0; res_nto = 0;
      res_busy_ok = 1; res_ready_after = 0; res_div_seen = 0; res_mult_seen = 0; res_dctrl_pulse = 0;
      @(negedge clk);
      op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
      @(posedge clk);
      #1;
      op_valid = 1'b0; op_code = 2'($urandom); op_a = $urandom; op_b = $urandom;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (div_ctrl) res_div_seen = 1;
         if (mult_ctrl) res_mult_seen = 1;
         if (done) res_ndone++;
         if (div_zero_exc) res_nzero++;
         if (timeout_err) res_nto++;
         if (res_lat == 0 && (done || div_zero_exc || timeout_err)) begin
            res_lat = c;
            res_dctrl_pulse = div_ctrl;
         end else if (res_lat == 0 && op_ready) begin
            res_busy_ok = 0;
         end
         if (res_lat != 0 && c == res_lat + 1) begin
            res_ready_after = op_ready;
            break;
         end
      end
      $display("op=%0d a=%h b=%h lat=%0d done=%0d zero=%0d to=%0d hi=%h lo=%h",
               code, a, b, res_lat, res_ndone, res_nzero, res_nto, hi, lo);
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
      checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", op_ready); end
      checks++; if ({done, div_zero_exc, timeout_err, div_ctrl, div_rst, mult_ctrl, mult_rst} !== 7'd0) begin
         errors++; $display("FAIL reset_flags got %b want 0", {done, div_zero_exc, timeout_err, div_ctrl, div_rst, mult_ctrl, mult_rst}); end
      checks++; if ({div_dividendo, div_divisor} !== 64'd0) begin errors++; $display("FAIL reset_operands got %h want 0", {div_dividendo, div_divisor}); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_div_basic();
      div_lat = 10;
      run_op(OP_DIV, 32'd7, 32'd2);
      checks++; if (res_lat !== 13) begin errors++; $display("FAIL div7_lat got %0d want 13", res_lat); end
      checks++; if (res_ndone !== 1 || res_nzero !== 0) begin errors++; $display("FAIL div7_pulse got done=%0d zero=%0d want 1/0", res_ndone, res_nzero); end
      checks++; if (hi !== 32'h1 || lo !== 32'h3) begin errors++; $display("FAIL div7_hilo got %h/%h want 1/3", hi, lo); end
      checks++; if (!res_busy_ok || !res_ready_after) begin errors++; $display("FAIL div7_ready got busy_ok=%0d after=%0d want 1/1", res_busy_ok, res_ready_after); end
      checks++; if (res_mult_seen !== 1'b0) begin errors++; $display("FAIL div7_mult_ctrl got %0d want 0", res_mult_seen); end
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL divneg_hilo got %h/%h want ffffffff/fffffffd", hi, lo); end
      m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD;
   endtask

   task automatic test_div_zero();
      run_op(OP_MTHI, 32'hAAAA_5555, 32'd0);
      checks++; if (res_lat !== 1 || res_ndone !== 1) begin errors++; $display("FAIL mthi_lat got lat=%0d done=%0d want 1/1", res_lat, res_ndone); end
      checks++; if (hi !== 32'hAAAA_5555 || lo !== m_lo) begin errors++; $display("FAIL mthi_hilo got %h/%h want aaaa5555/%h", hi, lo, m_lo); end
      m_hi = 32'hAAAA_5555;
      run_op(OP_DIV, 32'd5, 32'd0);
      checks++; if (res_nzero !== 1 || res_ndone !== 0 || res_lat !== 3) begin
         errors++; $display("FAIL divzero_pulse got zero=%0d done=%0d lat=%0d want 1/0/3", res_nzero, res_ndone, res_lat); end
      checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL divzero_hilo got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
      checks++; if (res_dctrl_pulse !== 1'b0) begin errors++; $display("FAIL divzero_ctrl got %b want 0", res_dctrl_pulse); end
   endtask

   task automatic test_mult();
      mult_lat = 5; mult_force = 1; force_hi = 32'h1; force_lo = 32'h2;
      run_op(OP_MULT, 32'd3, 32'd4);
      checks++; if (res_lat !== 8 || res_ndone !== 1) begin errors++; $display("FAIL mult_lat got lat=%0d done=%0d want 8/1", res_lat, res_ndone); end
      checks++; if (hi !== 32'h1 || lo !== 32'h2) begin errors++; $display("FAIL mult_hilo got %h/%h want 1/2", hi, lo); end
      checks++; if (res_div_seen !== 1'b0) begin errors++; $display("FAIL mult_div_ctrl got %0d want 0", res_div_seen); end
      m_hi = 32'h1; m_lo = 32'h2;
   endtask

   task automatic test_timeout();
      mult_never = 1;
      run_op(OP_MULT, 32'd9, 32'd9);
      checks++; if (res_nto !== 1 || res_ndone !== 0 || res_lat !== TO + 2) begin
         errors++; $display("FAIL timeout_pulse got to=%0d done=%0d lat=%0d want 1/0/%0d", res_nto, res_ndone, res_lat, TO + 2); end
      checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL timeout_hilo got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
      checks++; if (!res_ready_after) begin errors++; $display("FAIL timeout_ready got 0 want 1"); end
      mult_never = 0;
   endtask

   task automatic test_boundary();
      force_hi = 32'h11; force_lo = 32'h22;
      mult_lat = TO - 1;
      run_op(OP_MULT, 32'd1, 32'd1);
      checks++; if (res_ndone !== 1 || res_nto !== 0 || res_lat !== TO + 2) begin
         errors++; $display("FAIL edge_done got done=%0d to=%0d lat=%0d want 1/0/%0d", res_ndone, res_nto, res_lat, TO + 2); end
      checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL edge_hilo got %h/%h want 11/22", hi, lo); end
      m_hi = 32'h11; m_lo = 32'h22;
      mult_lat = TO; force_hi = 32'h77;
      run_op(OP_MULT, 32'd1, 32'd1);
      checks++; if (res_nto !== 1 || res_ndone !== 0 || hi !== m_hi) begin
         errors++; $display("FAIL late_to got to=%0d done=%0d hi=%h want 1/0/%h", res_nto, res_ndone, hi, m_hi); end
      mult_force = 0;
   endtask

   task automatic test_reset_mid();
      div_lat = 30;
      @(negedge clk);
      op_valid = 1'b1; op_code = OP_DIV; op_a = 32'd100; op_b = 32'd7;
      @(posedge clk);
      #1 op_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midrst_hilo got %h/%h want 0/0", hi, lo); end
      checks++; if ({done, div_zero_exc, timeout_err, div_ctrl, div_rst, mult_ctrl, mult_rst} !== 7'd0) begin
         errors++; $display("FAIL midrst_flags got %b want 0", {done, div_zero_exc, timeout_err, div_ctrl, div_rst, mult_ctrl, mult_rst}); end
      @(negedge clk);
      reset = 1'b1;
      m_hi = '0; m_lo = '0;
      div_lat = 4;
      run_op(OP_DIV, 32'd9, 32'd3);
      checks++; if (res_ndone !== 1 || res_lat !== 7) begin errors++; $display("FAIL postrst_lat got done=%0d lat=%0d want 1/7", res_ndone, res_lat); end
      checks++; if (hi !== 32'd0 || lo !== 32'd3) begin errors++; $display("FAIL postrst_hilo got %h/%h want 0/3", hi, lo); end
      m_lo = 32'd3;
   endtask

   task automatic test_random();
      logic [1:0]  code;
      logic [31:0] a, b;
      int          exp_lat, exp_kind, got_kind;
      longint      p;
      for (int i = 0; i < 24; i++) begin
         code = 2'($urandom); a = $urandom; b = $urandom;
         if ($urandom_range(0, 4) == 0) b = 32'd0;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
         div_lat = $urandom_range(1, 20); mult_lat = $urandom_range(1, 20);
         mult_never = (code == OP_MULT) && ($urandom_range(0, 7) == 0);
         div_noise  = (code == OP_MULT) && ($urandom_range(0, 1) == 1);
         mult_noise = (code == OP_DIV) && ($urandom_range(0, 1) == 1);
         exp_kind = 0;
         if (code == OP_MTHI) begin m_hi = a; exp_lat = 1; end
         else if (code == OP_MTLO) begin m_lo = a; exp_lat = 1; end
         else if (code == OP_DIV) begin
            if (b == 32'd0) begin exp_kind = 1; exp_lat = 3; end
            else begin m_lo = $signed(a) / $signed(b); m_hi = $signed(a) % $signed(b); exp_lat = 3 + div_lat; end
         end else begin
            if (mult_never) begin exp_kind = 2; exp_lat = TO + 2; end
            else begin
               p = longint'($signed(a)) * longint'($signed(b));
               m_hi = p[63:32]; m_lo = p[31:0]; exp_lat = 3 + mult_lat;
            end
         end
         run_op(code, a, b);
         div_noise = 0; mult_noise = 0; mult_never = 0;
         got_kind = (res_ndone == 1 && res_nzero == 0 && res_nto == 0) ? 0 :
                    (res_ndone == 0 && res_nzero == 1 && res_nto == 0) ? 1 :
                    (res_ndone == 0 && res_nzero == 0 && res_nto == 1) ? 2 : 9;
         checks++; if (got_kind !== exp_kind || res_lat !== exp_lat) begin
            errors++; $display("FAIL rand%0d_outcome got kind=%0d lat=%0d want kind=%0d lat=%0d", i, got_kind, res_lat, exp_kind, exp_lat); end
         checks++; if (hi !== m_hi || lo !== m_lo) begin
            errors++; $display("FAIL rand%0d_hilo got %h/%h want %h/%h", i, hi, lo, m_hi, m_lo); end
      end
   endtask

   initial begin
      test_reset();
      test_div_basic();
      test_div_zero();
      test_mult();
      test_timeout();
      test_boundary();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
